// File: rtl/output_buffer_reader.sv
// ============================================================================
// output_buffer_reader : slot-based circular buffer drained over valid/ready
// Revision: 1.0
// ============================================================================
`default_nettype none

module output_buffer_reader #(
  parameter int DATA_W = 8,
  parameter int SLOTS  = 5,
  localparam int CNT_W = $clog2(SLOTS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int PTR_W = $clog2(SLOTS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

  logic [DATA_W-1:0] slot_q [SLOTS];
  logic [DATA_W-1:0] slot_d [SLOTS];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_ack_q, wr_ack_d;
  logic              overflow_q, overflow_d;

  logic rd_fire;
  logic wr_fire;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign rd_valid = !empty;
  assign rd_data  = rd_valid ? slot_q[rd_ptr_q] : '0;
  assign wr_ack   = wr_ack_q;
  assign overflow = overflow_q;

  // A read in the same cycle frees the head slot, so a full buffer can still take a write.
  assign rd_fire = rd_valid && rd_ready;
  assign wr_fire = wr_en && (!full || rd_fire);

  always_comb begin
    slot_d     = slot_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    wr_ack_d   = wr_fire;
    overflow_d = overflow_q;

    if (wr_fire) begin
      slot_d[wr_ptr_q] = wr_data;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    if (rd_fire) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Dropped write wins over a simultaneous clear.
    if (wr_en && !wr_fire) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++) begin
        slot_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_ack_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_ack_q   <= wr_ack_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_output_buffer_reader.sv
// ============================================================================
// tb_output_buffer_reader : queue-model bench for output_buffer_reader
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_output_buffer_reader;

  localparam int DATA_W = 8;
  localparam int SLOTS  = 5;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ack;
  logic              rd_valid;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              ovf_clr = 1'b0;

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  output_buffer_reader #(.DATA_W(DATA_W), .SLOTS(SLOTS)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO queue plus the two flag bits.
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] out_log[$];
  bit m_ack = 0;
  bit m_ovf = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ack = 0;
      m_ovf = 0;
    end else begin
      bit rf, wf;
      rf = (m_q.size() != 0) && rd_ready;
      wf = wr_en && ((m_q.size() < SLOTS) || rf);
      if (rf) out_log.push_back(m_q.pop_front());
      if (wf) m_q.push_back(wr_data);
      m_ack = wf;
      if (wr_en && !wf) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_rd_valid", 32'(rd_valid), 32'(m_q.size() != 0));
      chk("m_rd_data",  32'(rd_data),  (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
      chk("m_count",    32'(count),    32'(m_q.size()));
      chk("m_full",     32'(full),     32'(m_q.size() == SLOTS));
      chk("m_empty",    32'(empty),    32'(m_q.size() == 0));
      chk("m_wr_ack",   32'(wr_ack),   32'(m_ack));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string nm, input logic [DATA_W-1:0] exp[$]);
    chk({nm, "_len"}, 32'(out_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < out_log.size(); i++)
      chk(nm, 32'(out_log[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [DATA_W-1:0] exp[$];

    // Reset held while wr_en toggles.
    step();
    cmp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_en = ~wr_en;
      wr_data = 8'hEE;
      step();
    end
    wr_en = 1'b0;
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rd_data",  32'(rd_data),  32'h0);
    chk("rst_empty",    32'(empty),    32'h1);
    chk("rst_count",    32'(count),    32'h0);
    chk("rst_wr_ack",   32'(wr_ack),   32'h0);
    rst_n = 1'b1;
    step();

    // Fill to full, then one dropped write.
    for (int i = 0; i < SLOTS; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h11 + i);
      step();
      chk("fill_ack", 32'(wr_ack), 32'h1);
    end
    chk("fill_count", 32'(count), 32'd5);
    chk("fill_full",  32'(full),  32'h1);
    wr_data = 8'h16;
    step();
    wr_en = 1'b0;
    chk("ovf_ack",   32'(wr_ack),   32'h0);
    chk("ovf_flag",  32'(overflow), 32'h1);
    chk("ovf_count", 32'(count),    32'd5);
    chk("ovf_head",  32'(rd_data),  32'h11);

    // Drain in arrival order.
    out_log.delete();
    rd_ready = 1'b1;
    for (int i = 0; i < SLOTS; i++) step();
    rd_ready = 1'b0;
    exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    chk_log("drain", exp);
    chk("drain_empty", 32'(empty),    32'h1);
    chk("drain_data",  32'(rd_data),  32'h0);
    chk("drain_ovf",   32'(overflow), 32'h1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'h0);

    // Wrap-around with occupancy held at 1..2.
    out_log.delete();
    for (int i = 0; i < 12; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'hA0 + i);
      rd_ready = (i >= 2);
      step();
    end
    wr_en = 1'b0;
    rd_ready = 1'b1;
    step();
    step();
    rd_ready = 1'b0;
    exp.delete();
    for (int i = 0; i < 12; i++) exp.push_back(8'(8'hA0 + i));
    chk_log("wrap", exp);
    chk("wrap_count", 32'(count), 32'h0);

    // Simultaneous write and read while full.
    for (int i = 0; i < SLOTS; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h21 + i);
      step();
    end
    out_log.delete();
    chk("sim_head", 32'(rd_data), 32'h21);
    wr_data = 8'h30;
    rd_ready = 1'b1;
    step();
    wr_en = 1'b0;
    chk("sim_count", 32'(count),    32'd5);
    chk("sim_ovf",   32'(overflow), 32'h0);
    chk("sim_ack",   32'(wr_ack),   32'h1);
    chk("sim_head2", 32'(rd_data),  32'h22);
    for (int i = 0; i < SLOTS; i++) step();
    rd_ready = 1'b0;
    exp = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h30};
    chk_log("sim", exp);

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h41 + i);
      step();
    end
    wr_en = 1'b0;
    chk("arst_pre_count", 32'(count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(rd_valid), 32'h0);
    chk("arst_data",  32'(rd_data),  32'h0);
    chk("arst_count", 32'(count),    32'h0);
    chk("arst_empty", 32'(empty),    32'h1);
    step();
    rst_n = 1'b1;
    step();
    out_log.delete();
    wr_en = 1'b1;
    wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    chk("post_data",  32'(rd_data), 32'h55);
    chk("post_count", 32'(count),   32'd1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    exp = '{8'h55};
    chk_log("post", exp);
    chk("post_empty", 32'(empty), 32'h1);
    step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
